// File: rtl/spi_slave_burst.sv
// SPI slave bridging an external SPI master onto the on-chip register bus.
// Supports all four SPI modes, auto-increment bursts and frame-error reporting.
`timescale 1ns/1ps
module spi_slave_burst #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_EN    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SPI_CLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              Data_WE,
  output logic              Data_RE,
  output logic [ADDR_W-1:0] Data_Addr,
  output logic [DATA_W-1:0] Data_Write,
  input  logic [DATA_W-1:0] Data_Read,
  output logic              Frame_Err,
  output logic              Busy
);

  localparam int HDR_W = ADDR_W + 1;
  localparam int MAX_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_s, cs_s, mosi_s, sck_prev;
  logic                   rise, fall, lead, trail, sample_edge, shift_edge;
  logic                   cs_armed;
  logic [CNT_W-1:0]       bit_cnt;
  logic [HDR_W-2:0]       hdr_sr;
  logic [HDR_W-1:0]       hdr_next;
  logic [DATA_W-2:0]      rx_sr;
  logic [DATA_W-1:0]      rx_next;
  logic [DATA_W-1:0]      tx_sr;
  logic                   rw, rd_pending;
  logic [ADDR_W-1:0]      addr;
  logic                   hdr_last, word_last;

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign rise        = sck_s & ~sck_prev;
  assign fall        = ~sck_s & sck_prev;
  assign lead        = (CPOL != 0) ? fall : rise;
  assign trail       = (CPOL != 0) ? rise : fall;
  assign sample_edge = (CPHA != 0) ? trail : lead;
  assign shift_edge  = (CPHA != 0) ? lead : trail;
  assign hdr_next    = {hdr_sr, mosi_s};
  assign rx_next     = {rx_sr, mosi_s};
  assign hdr_last    = (bit_cnt == CNT_W'(HDR_W - 1));
  assign word_last   = (bit_cnt == CNT_W'(DATA_W - 1));

  // Bring the asynchronous SPI pins into the Clk domain and keep SCK history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sck_prev  <= sck_s;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; chip-select deassertion takes priority over any SCK edge.
  always_comb begin
    state_next = state;
    Busy       = (state != IDLE);
    unique case (state)
      IDLE: if (!cs_s && cs_armed) state_next = HDR;
      HDR: begin
        if (cs_s)                          state_next = IDLE;
        else if (sample_edge && hdr_last)  state_next = DATA;
      end
      DATA: begin
        if (cs_s) state_next = IDLE;
        else if (sample_edge && word_last && (BURST_EN == 0)) state_next = DONE;
      end
      DONE: if (cs_s) state_next = IDLE;
    endcase
  end

  // Shift registers, bus strobes and MISO; read data is captured one Clk after
  // the bus has seen Data_RE, ahead of the shift edge that presents its MSB.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      SPI_MISO   <= 1'b0;
      Data_WE    <= 1'b0;
      Data_RE    <= 1'b0;
      Data_Addr  <= '0;
      Data_Write <= '0;
      Frame_Err  <= 1'b0;
      cs_armed   <= 1'b0;
      bit_cnt    <= '0;
      hdr_sr     <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      rw         <= 1'b0;
      rd_pending <= 1'b0;
      addr       <= '0;
    end else begin
      Data_WE    <= 1'b0;
      Data_RE    <= 1'b0;
      Frame_Err  <= 1'b0;
      rd_pending <= Data_RE;
      if (rd_pending) tx_sr <= Data_Read;
      if (cs_s) cs_armed <= 1'b1;
      unique case (state)
        IDLE: begin
          SPI_MISO <= 1'b0;
          if (!cs_s && cs_armed) begin
            cs_armed <= 1'b0;
            bit_cnt  <= '0;
            hdr_sr   <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
          end
        end
        HDR: begin
          SPI_MISO <= 1'b0;
          if (cs_s) begin
            Frame_Err <= (bit_cnt != '0);
          end else if (sample_edge) begin
            hdr_sr <= hdr_next[HDR_W-2:0];
            if (hdr_last) begin
              rw        <= hdr_next[HDR_W-1];
              addr      <= hdr_next[ADDR_W-1:0];
              Data_Addr <= hdr_next[ADDR_W-1:0];
              Data_RE   <= ~hdr_next[HDR_W-1];
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (cs_s) begin
            SPI_MISO  <= 1'b0;
            Frame_Err <= (bit_cnt != '0);
          end else begin
            if (shift_edge) begin
              if (rw) begin
                SPI_MISO <= 1'b0;
              end else begin
                SPI_MISO <= tx_sr[DATA_W-1];
                tx_sr    <= tx_sr << 1;
              end
            end
            if (sample_edge) begin
              rx_sr <= rx_next[DATA_W-2:0];
              if (word_last) begin
                bit_cnt <= '0;
                if (rw) begin
                  Data_WE    <= 1'b1;
                  Data_Write <= rx_next;
                  Data_Addr  <= addr;
                end
                if (BURST_EN != 0) begin
                  addr <= addr + 1'b1;
                  if (!rw) begin
                    Data_Addr <= addr + 1'b1;
                    Data_RE   <= 1'b1;
                  end
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        DONE: SPI_MISO <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: one instance per SPI mode, a bit-banged
// master, a one-cycle-latency register-bus responder and a strobe monitor.
`timescale 1ns/1ps
module tb_spi_slave_burst;

  localparam int HALF = 80;

  typedef struct {
    int         inst;
    logic [6:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sck = 4'b1100;
  logic [3:0]  cs  = 4'b1111;
  logic        mosi = 1'b0;
  logic [3:0]  miso, we, re, ferr, busy;
  logic [6:0]  addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];

  int vecs = 0;
  int errs = 0;
  ev_t we_q[$];
  ev_t re_q[$];
  int ferr_cnt = 0;
  int clash_cnt = 0;
  logic [127:0] rx;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_burst #(
      .ADDR_W(7), .DATA_W(32), .CPOL(g / 2), .CPHA(g % 2),
      .SYNC_STAGES(2), .BURST_EN(1)
    ) dut (
      .Clk(clk), .Reset(rst),
      .SPI_CLK(sck[g]), .SPI_CS(cs[g]), .SPI_MOSI(mosi), .SPI_MISO(miso[g]),
      .Data_WE(we[g]), .Data_RE(re[g]), .Data_Addr(addr[g]),
      .Data_Write(wdata[g]), .Data_Read(rdata[g]),
      .Frame_Err(ferr[g]), .Busy(busy[g])
    );
  end

  function automatic logic [31:0] mem_val(input logic [6:0] a);
    case (a)
      7'h03:   return 32'h1234_5678;
      7'h10:   return 32'hA5C3_0F96;
      7'h11:   return 32'h5A3C_F069;
      default: return {16'hC0DE, 9'h000, a};
    endcase
  endfunction

  // Register-bus responder: read data valid one Clk after Data_RE.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (re[i]) rdata[i] <= mem_val(addr[i]);
  end

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) we_q.push_back('{i, addr[i], wdata[i]});
      if (re[i]) re_q.push_back('{i, addr[i], 32'h0});
      if (ferr[i]) ferr_cnt++;
      if (we[i] && re[i]) clash_cnt++;
    end
  end

  function automatic logic [47:0] we_at(input int k);
    if (k < we_q.size()) return {we_q[k].inst[7:0], 1'b0, we_q[k].a, we_q[k].d};
    return 'x;
  endfunction

  function automatic logic [15:0] re_at(input int k);
    if (k < re_q.size()) return {re_q[k].inst[7:0], 1'b0, re_q[k].a};
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    we_q.delete();
    re_q.delete();
    ferr_cnt = 0;
  endtask

  // Bit-banged master; rx collects MISO at each sample edge, MSB first.
  task automatic spi_xfer(input int m, input int nbits, input logic [127:0] tx,
                          output logic [127:0] rxo, input bit raise_cs);
    logic cpol, cpha, b;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rxo = '0;
    @(posedge clk); #2;
    sck[m] = cpol;
    cs[m] = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      b = tx[nbits-1-i];
      if (!cpha) begin
        mosi = b;
        #HALF;
        sck[m] = ~cpol;
        rxo = {rxo[126:0], miso[m]};
        #HALF;
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        mosi = b;
        #HALF;
        sck[m] = cpol;
        rxo = {rxo[126:0], miso[m]};
        #HALF;
      end
    end
    #HALF;
    if (raise_cs) begin
      cs[m] = 1'b1;
      repeat (10) @(posedge clk);
    end
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) rdata[i] = '0;
    repeat (5) @(negedge clk);
    check("reset_flags", {miso, we, re, ferr, busy}, '0);
    check("reset_bus", {addr[0], addr[3], wdata[0], wdata[3]}, '0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Single write and single read in each SPI mode.
    for (int m = 0; m < 4; m++) begin
      clear_log();
      spi_xfer(m, 40, {88'h0, 8'h85, 32'hDEAD_BEEF}, rx, 1'b1);
      check($sformatf("m%0d_wr_count", m), we_q.size(), 1);
      check($sformatf("m%0d_wr_txn", m), we_at(0), {8'(m), 1'b0, 7'h05, 32'hDEAD_BEEF});
      check($sformatf("m%0d_wr_no_re", m), re_q.size(), 0);
      check($sformatf("m%0d_wr_ferr", m), ferr_cnt, 0);
      check($sformatf("m%0d_wr_miso", m), rx[39:0], '0);

      clear_log();
      spi_xfer(m, 40, {88'h0, 8'h03, 32'h0}, rx, 1'b1);
      check($sformatf("m%0d_rd_hdr_miso", m), rx[39:32], 8'h00);
      check($sformatf("m%0d_rd_data", m), rx[31:0], 32'h1234_5678);
      check($sformatf("m%0d_rd_re_count", m), re_q.size(), 2);
      check($sformatf("m%0d_rd_re0", m), re_at(0), {8'(m), 1'b0, 7'h03});
      check($sformatf("m%0d_rd_re1", m), re_at(1), {8'(m), 1'b0, 7'h04});
      check($sformatf("m%0d_rd_no_we", m), we_q.size(), 0);
      check($sformatf("m%0d_rd_ferr", m), ferr_cnt, 0);
    end

    // Burst write wrapping past the top address.
    clear_log();
    spi_xfer(0, 104, {24'h0, 8'hFF, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}, rx, 1'b1);
    check("bw_count", we_q.size(), 3);
    check("bw_w0", we_at(0), {8'd0, 1'b0, 7'h7F, 32'hAAAA_0001});
    check("bw_w1", we_at(1), {8'd0, 1'b0, 7'h00, 32'hBBBB_0002});
    check("bw_w2", we_at(2), {8'd0, 1'b0, 7'h01, 32'hCCCC_0003});
    check("bw_ferr", ferr_cnt, 0);

    // Burst read of two words.
    clear_log();
    spi_xfer(0, 72, {56'h0, 8'h10, 64'h0}, rx, 1'b1);
    check("br_data", rx[71:0], {8'h00, 32'hA5C3_0F96, 32'h5A3C_F069});
    check("br_re_count", re_q.size(), 3);
    check("br_re0", re_at(0), {8'd0, 1'b0, 7'h10});
    check("br_re1", re_at(1), {8'd0, 1'b0, 7'h11});
    check("br_re2", re_at(2), {8'd0, 1'b0, 7'h12});
    check("br_no_we", we_q.size(), 0);

    // Frame ends mid-word.
    clear_log();
    spi_xfer(1, 28, {100'h0, 8'h81, 20'hF0F0F}, rx, 1'b1);
    check("pw_no_we", we_q.size(), 0);
    check("pw_ferr", ferr_cnt, 1);

    // Frame ends mid-header.
    clear_log();
    spi_xfer(2, 3, {125'h0, 3'b101}, rx, 1'b1);
    check("ph_no_we", we_q.size(), 0);
    check("ph_no_re", re_q.size(), 0);
    check("ph_ferr", ferr_cnt, 1);

    // Reset in the middle of a data word with CS held low.
    clear_log();
    spi_xfer(0, 18, {110'h0, 8'h85, 10'h2AB}, rx, 1'b0);
    check("rst_pre_busy", busy[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_flags", {miso[0], we[0], re[0], ferr[0], busy[0]}, '0);
    check("rst_mid_bus", {addr[0], wdata[0]}, '0);
    rst = 1'b0;
    clear_log();
    spi_xfer(0, 40, {88'h0, 8'h86, 32'h0BAD_F00D}, rx, 1'b0);
    check("rst_ignored_busy", busy[0], 1'b0);
    check("rst_ignored_we", we_q.size(), 0);
    check("rst_ignored_ferr", ferr_cnt, 0);
    cs[0] = 1'b1;
    repeat (10) @(posedge clk);
    clear_log();
    spi_xfer(0, 40, {88'h0, 8'h85, 32'h0BAD_F00D}, rx, 1'b1);
    check("rst_next_txn", we_at(0), {8'd0, 1'b0, 7'h05, 32'h0BAD_F00D});
    check("rst_next_count", we_q.size(), 1);
    check("we_re_clash", clash_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
